// File: rtl/d_latch.sv
`default_nettype none
// ============================================================================
//  Module   : d_latch
//  Purpose  : Level-sensitive D latch of parameterisable width with an
//             asynchronous active-high reset and a complementary output.
//             Transparent while c is high, holds while c is low.
//  Revision : 1.0 - initial release
// ============================================================================
module d_latch #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  input  logic             rst
);

  // Stored value. Left uninitialised so that, before the first reset or the
  // first transparent phase, simulation shows it as unknown.
  logic [WIDTH-1:0] r_q;

  // Level-sensitive storage: reset dominates, then transparency, else hold.
  always_latch begin
    if (rst) begin
      r_q <= RESET_VALUE;
    end else if (c) begin
      r_q <= d;
    end
  end

  // Both outputs come from the single stored value, so qn is always ~q.
  assign q  = r_q;
  assign qn = ~r_q;

endmodule
`default_nettype wire

// File: tb/tb_d_latch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_d_latch
//  Purpose  : Directed, table-driven bench for d_latch. A 1-bit instance
//             (default reset value) and an 8-bit instance (non-zero reset
//             value) share enable and reset; the 1-bit one sees d[0].
//  Revision : 1.0 - initial release
// ============================================================================
module tb_d_latch;

  localparam logic [7:0] c_RV8 = 8'hC3;

  logic       c;
  logic       rst;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] qn8;
  logic       q1;
  logic       qn1;

  int checks = 0;
  int errors = 0;

  d_latch #(.WIDTH(1)) u_dut1 (
    .c   (c),
    .d   (d8[0]),
    .q   (q1),
    .qn  (qn1),
    .rst (rst)
  );

  d_latch #(.WIDTH(8), .RESET_VALUE(c_RV8)) u_dut8 (
    .c   (c),
    .d   (d8),
    .q   (q8),
    .qn  (qn8),
    .rst (rst)
  );

  typedef struct {
    logic       rst;
    logic       c;
    logic [7:0] d;
    logic [7:0] exp8;
    logic       exp1;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e8, input logic e1);
    chk({tag, " q8"},  q8,  e8);
    chk({tag, " qn8"}, qn8, ~e8);
    chk({tag, " q1"},  {7'd0, q1},  {7'd0, e1});
    chk({tag, " qn1"}, {7'd0, qn1}, {7'd0, ~e1});
  endtask

  initial begin
    // rst, c, d, expected q (8-bit), expected q (1-bit)
    vecs[0]  = '{1'b1, 1'b0, 8'h00, c_RV8, 1'b0}; // reset while closed
    vecs[1]  = '{1'b1, 1'b1, 8'hA5, c_RV8, 1'b0}; // reset beats enable
    vecs[2]  = '{1'b0, 1'b0, 8'hA5, c_RV8, 1'b0}; // release while closed
    vecs[3]  = '{1'b0, 1'b0, 8'h5A, c_RV8, 1'b0}; // d ignored until c rises
    vecs[4]  = '{1'b0, 1'b1, 8'h5A, 8'h5A, 1'b0}; // transparent
    vecs[5]  = '{1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1}; // follows d
    vecs[6]  = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1};
    vecs[7]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1}; // capture on close
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 8'hFF, 1'b1}; // hold
    vecs[9]  = '{1'b0, 1'b0, 8'hA5, 8'hFF, 1'b1}; // hold
    vecs[10] = '{1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1}; // reopen
    vecs[11] = '{1'b0, 1'b1, 8'h5A, 8'h5A, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 8'h5A, c_RV8, 1'b0}; // async reset mid-phase
    vecs[13] = '{1'b1, 1'b1, 8'hA5, c_RV8, 1'b0}; // d toggles under reset
    vecs[14] = '{1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1}; // release while open
    vecs[15] = '{1'b0, 1'b0, 8'hA5, 8'hA5, 1'b1}; // close, hold A5
    vecs[16] = '{1'b1, 1'b0, 8'hA5, c_RV8, 1'b0}; // reset discards hold
    vecs[17] = '{1'b0, 1'b0, 8'hFF, c_RV8, 1'b0}; // release closed again

    c   = 1'b0;
    rst = 1'b0;
    d8  = 8'h00;
    #2;

    for (int i = 0; i < 18; i++) begin
      rst = vecs[i].rst;
      c   = vecs[i].c;
      d8  = vecs[i].d;
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].exp8, vecs[i].exp1);
      #1;
    end

    // Simultaneous edge: d changes in the same timestep c falls.
    c  = 1'b1;
    d8 = 8'hA5;
    #1;
    chk_all("simul_open", 8'hA5, 1'b1);
    c  = 1'b0;
    d8 = 8'h5A;
    #1;
    chk_all("simul_close", 8'hA5, 1'b1);
    d8 = 8'h00;
    #1;
    chk_all("simul_hold", 8'hA5, 1'b1);

    // Transparent path responds to d within the timestep, repeatedly.
    c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d8 = (k % 2 == 0) ? 8'h3C : 8'hC2;
      #1;
      chk_all($sformatf("transp%0d", k), d8, d8[0]);
    end

    // Reset asserted while open and released while closed stays at reset value
    // until c rises again.
    rst = 1'b1;
    #1;
    chk_all("rst_open", c_RV8, 1'b0);
    c = 1'b0;
    d8 = 8'h81;
    #1;
    rst = 1'b0;
    #1;
    chk_all("rel_closed", c_RV8, 1'b0);
    c = 1'b1;
    #1;
    chk_all("reopen", 8'h81, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
